climate_zone_ctrl: RTL
======================

# climate_zone_ctrl

Multi-zone successor to the single-zone cooler/heater plus fan block in the Smart House climate subsystem. For each of `ZONES` zones it compares a measured temperature against a setpoint with a hysteresis band. It then drives a registered 4-bit power level and a heat/cool mode bit. Heat↔cool changeovers are enforced through a dead-time state. Each zone also gets a fan PWM whose duty cycle ramps toward a shared speed target.

## Interface
- `ZONES`, 2: number of independent zones (1..8).
- `PWM_W`, 8: PWM counter and duty width in bits.
- `HYST`, 2: hysteresis in degrees (0..15).
- `DEADTIME`, 16: changeover dead time in clock cycles (≥1).
- `RAMP_DIV`, 64: clock cycles per duty ramp step (≥1).

- `clk` in 1: clock, rising edge.
- `arst` in 1: asynchronous, active-low reset.
- `temp` in ZONES*8: measured temperature per zone, unsigned degrees; zone z is bits [8z+7:8z].
- `setpoint` in ZONES*8: target temperature per zone, same packing as `temp`.
- `speed` in PWM_W: fan duty target shared by all active zones.
- `chs_power` out ZONES*4: power level per zone, 0..15.
- `chs_mode` out ZONES: per-zone mode, heat=1 / cool=0.
- `pwm_data` out ZONES: per-zone fan PWM.
- `busy` out ZONES: zone is in HEAT, COOL or DEAD.

## Operation
- Per-zone FSM has four states: IDLE, HEAT, COOL, DEAD.
- Per-zone flags and registers: `last_vld` (a valid last mode exists), dead-time counter, pending-mode register.
- Demand is evaluated every cycle:
  - heat demand when `temp + HYST < setpoint`;
  - cool demand when `temp > setpoint + HYST`;
  - all comparisons use 9-bit unsigned arithmetic, so there is no wrap.
- IDLE:
  - demand with mode equal to `chs_mode`, or `last_vld`=0 → go directly to HEAT/COOL;
  - demand with mode opposite to `chs_mode` while `last_vld`=1 → DEAD.
- HEAT → IDLE when `temp >= setpoint`. HEAT → DEAD on cool demand.
- COOL → IDLE when `temp <= setpoint`. COOL → DEAD on heat demand.
- DEAD:
  - counter loads `DEADTIME-1` on entry and decrements each cycle;
  - at 0, demand is re-evaluated: heat → HEAT, cool → COOL, none → IDLE;
  - demand changes during DEAD never shorten the dead time.
- `chs_mode` updates only on entry to HEAT or COOL. The entry also sets `last_vld`. In IDLE and DEAD, `chs_mode` holds its last value.
- `chs_power` is registered from the next state:
  - HEAT/COOL: `min(15, |temp - setpoint|)`;
  - IDLE/DEAD: 0.
- `busy` is 1 in HEAT, COOL and DEAD.
- Fan PWM:
  - one free-running `PWM_W`-bit counter is shared by all zones and wraps at `2^PWM_W - 1` → 0;
  - per-zone duty target is `speed` in HEAT/COOL and 0 otherwise;
  - applied duty is latched only at counter wrap, so there are no mid-period glitches;
  - `pwm_data` = (counter < applied duty);
  - duty 0 → output constantly low; duty max → high for `2^PWM_W - 1` of `2^PWM_W` cycles.
- Zones are fully independent. Simultaneous demand in all zones is legal.

## Timing
- Reset, asynchronous and active-low. Every register clears:
  - state IDLE, `last_vld`=0;
  - `chs_power`=0, `chs_mode`=0, `pwm_data`=0, `busy`=0;
  - counter, duty registers and prescaler = 0.
- Assertion of `arst` mid-operation (including in DEAD) forces these values immediately. The first edge after release evaluates demand normally.
- Latency from an input change to the FSM state, `chs_power`, `chs_mode` and `busy`: 1 clock.
- Duty change becomes visible at the next counter wrap after the applied duty changes.
- DEAD lasts exactly `DEADTIME` cycles of `chs_power`=0 before the next active state.

## Configuration
- `CHS_SOFT_RAMP_EN` defined:
  - a shared prescaler produces a ramp tick every `RAMP_DIV` cycles;
  - on each tick, every zone's internal duty moves ±1 toward its target, saturating at the target;
  - the applied duty is still latched at wrap.
- `CHS_SOFT_RAMP_EN` undefined: internal duty equals target, applied at the next wrap. The prescaler is not built.

## Test plan
- Reset and hysteresis band:
  - release reset with `setpoint`=25, `temp`=26, HYST=2 → zone stays IDLE, `chs_power`=0, `pwm_data` constantly 0;
  - set `temp`=28 → COOL one cycle later, `chs_mode`=0, `chs_power`=3.
- First activation and exit:
  - `temp`=10, `setpoint`=30 → HEAT with no DEAD (`last_vld`=0), `chs_power`=15, `chs_mode`=1;
  - raise `temp` to 30 → IDLE, power 0, `chs_mode` stays 1.
- Changeover:
  - in HEAT, set `temp`=40, `setpoint`=30 → exactly 16 cycles of DEAD with `busy`=1 and power 0;
  - then COOL with power 10 and `chs_mode`=0.
  - Also drop `temp` back to 30 mid-DEAD → DEAD completes, then IDLE.
- PWM (feature undefined, PWM_W=8):
  - `speed`=64 in an active zone → after the next wrap, `pwm_data` high 64 of every 256 cycles;
  - `speed`=0 → constant low; `speed`=255 → high 255 of every 256 cycles.
- Soft ramp (`CHS_SOFT_RAMP_EN` defined, RAMP_DIV=4):
  - `speed`=8 → duty steps 0→8, reaching 8 after 32 cycles;
  - zone going IDLE → duty ramps down to 0.
- Zone independence and async reset:
  - zone 0 COOL while zone 1 HEAT → each output follows its own zone;
  - pulse `arst` low mid-DEAD → all outputs 0 immediately.

Source files
------------

// File: rtl/climate_zone_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : climate_zone_ctrl
// Purpose  : Multi-zone heat/cool controller with hysteresis, changeover dead
//            time and per-zone fan PWM. Optional macro CHS_SOFT_RAMP_EN adds a
//            prescaled soft ramp of the fan duty.
// Revision : 1.0 - initial release
// ============================================================================
module climate_zone_ctrl #(
    parameter int ZONES    = 2,
    parameter int PWM_W    = 8,
    parameter int HYST     = 2,
    parameter int DEADTIME = 16,
    parameter int RAMP_DIV = 64
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [ZONES*8-1:0]   temp,
    input  logic [ZONES*8-1:0]   setpoint,
    input  logic [PWM_W-1:0]     speed,
    output logic [ZONES*4-1:0]   chs_power,
    output logic [ZONES-1:0]     chs_mode,
    output logic [ZONES-1:0]     pwm_data,
    output logic [ZONES-1:0]     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam int               DW          = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0]    C_DEAD_LOAD = DW'(DEADTIME - 1);
    localparam logic [8:0]       C_HYST      = 9'(HYST);
    localparam logic [PWM_W-1:0] C_CNT_MAX   = '1;

    logic [PWM_W-1:0] r_cnt;
    logic             w_wrap;
    logic             w_tick;

    assign w_wrap = (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_cnt <= '0;
        else       r_cnt <= r_cnt + 1'b1;
    end

`ifdef CHS_SOFT_RAMP_EN
    localparam int              PRE_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(RAMP_DIV - 1);
    logic [PRE_W-1:0] r_pre;

    assign w_tick = (r_pre == C_PRE_MAX);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)       r_pre <= '0;
        else if (w_tick) r_pre <= '0;
        else             r_pre <= r_pre + 1'b1;
    end
`else
    logic w_unused_ramp_cfg;
    assign w_unused_ramp_cfg = (RAMP_DIV > 0);
    assign w_tick            = 1'b0;
`endif

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        state_t           r_state, w_next;
        logic [DW-1:0]    r_dcnt;
        logic             r_last_vld, r_mode, r_busy;
        logic [3:0]       r_power, w_power;
        logic [8:0]       w_t, w_s;
        logic [7:0]       w_diff;
        logic             w_heat, w_cool;
        logic [PWM_W-1:0] w_target, w_duty, r_applied;

        assign w_t    = {1'b0, temp[8*z +: 8]};
        assign w_s    = {1'b0, setpoint[8*z +: 8]};
        assign w_heat = (w_t + C_HYST) < w_s;
        assign w_cool = w_t > (w_s + C_HYST);
        assign w_diff = (w_t >= w_s) ? 8'(w_t - w_s) : 8'(w_s - w_t);

        always_comb begin
            w_next  = r_state;
            w_power = 4'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_heat)
                        w_next = (!r_last_vld || r_mode) ? ST_HEAT : ST_DEAD;
                    else if (w_cool)
                        w_next = (!r_last_vld || !r_mode) ? ST_COOL : ST_DEAD;
                end
                ST_HEAT: begin
                    if (w_cool)          w_next = ST_DEAD;
                    else if (w_t >= w_s) w_next = ST_IDLE;
                end
                ST_COOL: begin
                    if (w_heat)          w_next = ST_DEAD;
                    else if (w_t <= w_s) w_next = ST_IDLE;
                end
                ST_DEAD: begin
                    // Demand only matters once the full dead time has elapsed
                    if (r_dcnt == '0)
                        w_next = w_heat ? ST_HEAT : (w_cool ? ST_COOL : ST_IDLE);
                end
                default: w_next = ST_IDLE;
            endcase
            if (w_next == ST_HEAT || w_next == ST_COOL)
                w_power = (w_diff > 8'd15) ? 4'd15 : w_diff[3:0];
        end

        always_ff @(posedge clk or negedge arst) begin
            if (!arst) begin
                r_state    <= ST_IDLE;
                r_dcnt     <= '0;
                r_last_vld <= 1'b0;
                r_mode     <= 1'b0;
                r_power    <= 4'd0;
                r_busy     <= 1'b0;
            end else begin
                r_state <= w_next;
                r_power <= w_power;
                r_busy  <= (w_next != ST_IDLE);
                if (w_next == ST_DEAD && r_state != ST_DEAD)
                    r_dcnt <= C_DEAD_LOAD;
                else if (r_state == ST_DEAD && r_dcnt != '0)
                    r_dcnt <= r_dcnt - 1'b1;
                if (w_next == ST_HEAT || w_next == ST_COOL) begin
                    r_mode     <= (w_next == ST_HEAT);
                    r_last_vld <= 1'b1;
                end
            end
        end

        assign w_target = (r_state == ST_HEAT || r_state == ST_COOL) ? speed : '0;

`ifdef CHS_SOFT_RAMP_EN
        logic [PWM_W-1:0] r_duty;
        always_ff @(posedge clk or negedge arst) begin
            if (!arst) r_duty <= '0;
            else if (w_tick) begin
                if (r_duty < w_target)      r_duty <= r_duty + 1'b1;
                else if (r_duty > w_target) r_duty <= r_duty - 1'b1;
            end
        end
        assign w_duty = r_duty;
`else
        assign w_duty = w_target;
`endif

        // Duty is only taken at wrap so a PWM period is never cut short
        always_ff @(posedge clk or negedge arst) begin
            if (!arst)       r_applied <= '0;
            else if (w_wrap) r_applied <= w_duty;
        end

        assign chs_power[4*z +: 4] = r_power;
        assign chs_mode[z]         = r_mode;
        assign busy[z]             = r_busy;
        assign pwm_data[z]         = (r_cnt < r_applied);
    end

endmodule
`default_nettype wire
